// File: rtl/hack_cpu_ctrl.sv
// Multi-cycle control unit for a Hack CPU: sequences fetch, optional data read,
// ALU execute, optional data write and commit around an external ALU.
module hack_cpu_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [14:0] imem_addr,
  input  logic        imem_valid,
  input  logic [15:0] imem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [14:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [15:0] dmem_rdata,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  output logic        zx,
  output logic        nx,
  output logic        zy,
  output logic        ny,
  output logic        f,
  output logic        no,
  input  logic [15:0] alu_out,
  input  logic        alu_zr,
  input  logic        alu_ng,
  output logic [14:0] pc,
  output logic        retire,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    MEM_RD = 3'd2,
    EXEC   = 3'd3,
    MEM_WR = 3'd4,
    COMMIT = 3'd5
  } state_t;

  state_t      state, state_nx;
  logic [15:0] a_q, d_q, ir_q, mdr_q, res_q;
  logic [14:0] pc_q;
  logic        zr_q, ng_q, retire_q;
  logic        jmp;

  // Handshake: a request is held high, with its address stable, for as long as
  // the FSM sits in the requesting state; the transfer completes on the first
  // rising edge where valid/ack is high (including the request's first cycle).
  // valid/ack outside the requesting state carries no meaning and is ignored.
  assign imem_req   = rst_n && (state == FETCH);
  assign imem_addr  = pc_q;
  assign dmem_req   = rst_n && ((state == MEM_RD) || (state == MEM_WR));
  assign dmem_we    = rst_n && (state == MEM_WR);
  assign dmem_addr  = a_q[14:0];
  assign dmem_wdata = res_q;

  assign alu_x = d_q;
  assign alu_y = ir_q[12] ? mdr_q : a_q;
  assign {zx, nx, zy, ny, f, no} = ir_q[15] ? ir_q[11:6] : 6'b0;

  assign pc        = pc_q;
  assign retire    = retire_q;
  assign dbg_state = state;

  // Flags come from the EXEC-registered copies, never the live ALU inputs.
  assign jmp = (ir_q[2] & ng_q) | (ir_q[1] & zr_q) | (ir_q[0] & ~ng_q & ~zr_q);

  always_comb begin
    state_nx = state;
    case (state)
      FETCH:   if (imem_valid) state_nx = DECODE;
      DECODE: begin
        if (!ir_q[15])     state_nx = FETCH;
        else if (ir_q[12]) state_nx = MEM_RD;
        else               state_nx = EXEC;
      end
      MEM_RD:  if (dmem_ack) state_nx = EXEC;
      EXEC:    state_nx = ir_q[3] ? MEM_WR : COMMIT;
      MEM_WR:  if (dmem_ack) state_nx = COMMIT;
      COMMIT:  state_nx = FETCH;
      default: state_nx = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q      <= 16'h0;
      d_q      <= 16'h0;
      ir_q     <= 16'h0;
      mdr_q    <= 16'h0;
      res_q    <= 16'h0;
      pc_q     <= 15'h0;
      zr_q     <= 1'b0;
      ng_q     <= 1'b0;
      retire_q <= 1'b0;
    end else begin
      retire_q <= 1'b0;
      case (state)
        FETCH:  if (imem_valid) ir_q <= imem_rdata;
        DECODE: begin
          if (!ir_q[15]) begin
            a_q      <= {1'b0, ir_q[14:0]};
            pc_q     <= pc_q + 15'd1;
            retire_q <= 1'b1;
          end
        end
        MEM_RD: if (dmem_ack) mdr_q <= dmem_rdata;
        EXEC: begin
          res_q <= alu_out;
          zr_q  <= alu_zr;
          ng_q  <= alu_ng;
        end
        COMMIT: begin
          // The jump target reads a_q before this edge's destination write.
          if (ir_q[5]) a_q <= res_q;
          if (ir_q[4]) d_q <= res_q;
          pc_q     <= jmp ? a_q[14:0] : pc_q + 15'd1;
          retire_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Bench for hack_cpu_ctrl: memory/ALU environment with random wait states and
// an instruction-level Hack machine model that predicts every retire and write.
module tb_hack_cpu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req, dmem_req, dmem_we;
  logic [14:0] imem_addr, dmem_addr, pc;
  logic        imem_valid = 1'b0;
  logic [15:0] imem_rdata = 16'h0;
  logic [15:0] dmem_wdata;
  logic        dmem_ack = 1'b0;
  logic [15:0] dmem_rdata = 16'h0;
  logic [15:0] alu_x, alu_y, alu_out;
  logic        zx, nx, zy, ny, f, no, alu_zr, alu_ng, retire;
  logic [2:0]  dbg_state;

  hack_cpu_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .alu_x(alu_x), .alu_y(alu_y), .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no),
    .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng),
    .pc(pc), .retire(retire), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_err = 0;
  int n_ret = 0;
  int last_ret_cyc = 0;
  int rd_cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- environment: memories and ALU ----------------
  logic [15:0] imem [0:32767];
  logic [15:0] dmem [0:32767];
  int imin = 0, imax = 0, dmin = 0, dmax = 0;
  bit spur = 1'b0;
  int iw = 0, dw = 0;
  bit ib = 1'b0, db = 1'b0;

  function automatic logic [15:0] hack_alu(input logic [15:0] x, input logic [15:0] y,
                                           input logic [5:0] c);
    logic [15:0] xx, yy, o;
    xx = c[5] ? 16'h0 : x;
    if (c[4]) xx = ~xx;
    yy = c[3] ? 16'h0 : y;
    if (c[2]) yy = ~yy;
    o = c[1] ? (xx + yy) : (xx & yy);
    if (c[0]) o = ~o;
    return o;
  endfunction

  assign alu_out = hack_alu(alu_x, alu_y, {zx, nx, zy, ny, f, no});
  assign alu_zr  = (alu_out == 16'h0);
  assign alu_ng  = alu_out[15];

  always @(posedge clk) begin
    #2;
    if (imem_req) begin
      if (!ib) begin ib = 1'b1; iw = $urandom_range(imax, imin); end
      if (iw == 0) begin imem_valid = 1'b1; imem_rdata = imem[imem_addr]; end
      else begin iw--; imem_valid = 1'b0; imem_rdata = 16'($urandom); end
    end else begin
      ib = 1'b0;
      imem_valid = spur && ($urandom_range(0, 1) == 1);
      imem_rdata = 16'($urandom);
    end
    if (dmem_req) begin
      if (!db) begin db = 1'b1; dw = $urandom_range(dmax, dmin); end
      if (dw == 0) begin dmem_ack = 1'b1; dmem_rdata = dmem[dmem_addr]; end
      else begin dw--; dmem_ack = 1'b0; dmem_rdata = 16'($urandom); end
    end else begin
      db = 1'b0;
      dmem_ack = spur && ($urandom_range(0, 1) == 1);
      dmem_rdata = 16'($urandom);
    end
  end

  // ---------------- reference model: one Hack instruction per fetch ----------------
  logic [14:0] mpc = 15'h0;
  logic [15:0] ma = 16'h0, md = 16'h0;
  logic [30:0] exp_q[$];   // {addr, data} of predicted data writes
  logic [46:0] ret_q[$];   // {pc, A, D} after each predicted retire

  task automatic model_step(input logic [15:0] ins);
    logic [15:0] y, r;
    logic        jmp;
    if (!ins[15]) begin
      ma  = {1'b0, ins[14:0]};
      mpc = mpc + 15'd1;
    end else begin
      y   = ins[12] ? dmem[ma[14:0]] : ma;
      r   = hack_alu(md, y, ins[11:6]);
      jmp = (ins[2] && r[15]) || (ins[1] && r == 16'h0) || (ins[0] && !r[15] && r != 16'h0);
      if (ins[3]) exp_q.push_back({ma[14:0], r});
      mpc = jmp ? ma[14:0] : mpc + 15'd1;
      if (ins[5]) ma = r;
      if (ins[4]) md = r;
    end
    ret_q.push_back({mpc, ma, md});
  endtask

  // ---------------- monitor (samples on the falling edge) ----------------
  logic        prev_ireq = 1'b0, prev_dreq = 1'b0;
  logic [14:0] prev_iaddr = 15'h0, prev_daddr = 15'h0;

  always @(negedge clk) begin
    logic [30:0] e;
    logic [46:0] r;
    if (!rst_n) begin
      mpc = 15'h0; ma = 16'h0; md = 16'h0;
      exp_q.delete(); ret_q.delete();
      prev_ireq = 1'b0; prev_dreq = 1'b0;
    end else begin
      if (imem_req && prev_ireq) check("imem_addr_hold", imem_addr, prev_iaddr);
      if (dmem_req && prev_dreq) check("dmem_addr_hold", dmem_addr, prev_daddr);
      if (dmem_req && !dmem_we) rd_cyc++;
      if (dmem_req && dmem_we && dmem_ack) begin
        if (exp_q.size() == 0) check("unexpected_write", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("wr_addr", dmem_addr, e[30:16]);
          check("wr_data", dmem_wdata, e[15:0]);
        end
        dmem[dmem_addr] = dmem_wdata;
      end
      if (retire) begin
        n_ret++;
        last_ret_cyc = cyc;
        check("pending_write", exp_q.size(), 0);
        if (ret_q.size() == 0) check("unexpected_retire", 1, 0);
        else begin
          r = ret_q.pop_front();
          check("ret_pc", pc, r[46:32]);
          check("ret_a", dmem_addr, r[30:16]);
          check("ret_d", alu_x, r[15:0]);
        end
      end
      if (imem_req && imem_valid) begin
        check("fetch_addr", imem_addr, mpc);
        model_step(imem_rdata);
      end
      prev_ireq = imem_req; prev_iaddr = imem_addr;
      prev_dreq = dmem_req; prev_daddr = dmem_addr;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic reset_on();
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_imem_req", imem_req, 0);
    check("rst_dmem_req", dmem_req, 0);
    check("rst_dmem_we", dmem_we, 0);
    check("rst_retire", retire, 0);
    check("rst_pc", pc, 0);
    check("rst_a", dmem_addr, 0);
    check("rst_d", alu_x, 0);
  endtask

  task automatic reset_off();
    rst_n = 1'b1;
    #1;
    check("post_rst_imem_req", imem_req, 1);
    check("post_rst_imem_addr", imem_addr, 0);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 32768; i++) begin
      imem[i] = 16'h0;
      dmem[i] = 16'h0;
    end
  endtask

  task automatic set_waits(input int i0, input int i1, input int d0, input int d1, input bit sp);
    imin = i0; imax = i1; dmin = d0; dmax = d1; spur = sp;
  endtask

  task automatic run_retires(input int n, input int budget, input string tag);
    int target;
    int k;
    target = n_ret + n;
    k = 0;
    while (n_ret < target && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    if (n_ret < target) check({tag, "_timeout"}, n_ret, target);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int c0, c1, c2, k, r0;
    clear_mem();

    // @5 then D=A, zero-wait, followed by another A-instruction
    reset_on();
    set_waits(0, 0, 0, 0, 0);
    imem[0] = 16'h0005; imem[1] = 16'hEC10; imem[2] = 16'h0001;
    reset_off();
    run_retires(1, 50, "t1a"); c0 = last_ret_cyc;
    run_retires(1, 50, "t1b"); c1 = last_ret_cyc;
    check("t1_pc", pc, 2);
    check("t1_a", dmem_addr, 5);
    check("t1_d", alu_x, 5);
    run_retires(1, 50, "t1c"); c2 = last_ret_cyc;
    check("c_instr_cycles", c1 - c0, 4);
    check("a_instr_cycles", c2 - c1, 2);

    // D=5 then M=D+1 at A=5
    reset_on();
    clear_mem();
    imem[0] = 16'h0005; imem[1] = 16'hEC10; imem[2] = 16'hE7C8;
    reset_off();
    run_retires(3, 80, "t2");
    check("t2_mem5", dmem[5], 16'h0006);
    check("t2_pc", pc, 3);
    check("t2_a", dmem_addr, 5);
    check("t2_d", alu_x, 5);

    // D=M with the read ack delayed by three wait cycles
    reset_on();
    clear_mem();
    set_waits(0, 0, 3, 3, 0);
    dmem[100] = 16'hFFFF;
    imem[0] = 16'h0064; imem[1] = 16'hFC10;
    reset_off();
    rd_cyc = 0;
    run_retires(2, 80, "t3");
    check("t3_rd_req_cycles", rd_cyc, 4);
    check("t3_d", alu_x, 16'hFFFF);
    check("t3_pc", pc, 2);

    // Conditional jumps: JEQ taken, JEQ not taken, JLT taken
    reset_on();
    clear_mem();
    set_waits(0, 0, 0, 0, 0);
    imem[0]  = 16'hEA90; imem[1]  = 16'h002A; imem[2]  = 16'hE302;
    imem[42] = 16'hEFD0; imem[43] = 16'hE302;
    imem[44] = 16'h7FFF; imem[45] = 16'hEDD0; imem[46] = 16'h0064; imem[47] = 16'hE304;
    reset_off();
    run_retires(3, 80, "t4a");
    check("t4_jeq_taken", pc, 42);
    run_retires(2, 80, "t4b");
    check("t4_jeq_not_taken", pc, 44);
    run_retires(4, 80, "t4c");
    check("t4_d_neg", alu_x, 16'h8000);
    check("t4_jlt_taken", pc, 100);

    // AM=M+1: write goes to the old A, then A takes the result
    reset_on();
    clear_mem();
    dmem[7] = 16'h0009;
    imem[0] = 16'h0007; imem[1] = 16'hFDE8;
    reset_off();
    run_retires(2, 80, "t5");
    check("t5_mem7", dmem[7], 16'h000A);
    check("t5_a", dmem_addr, 10);
    check("t5_pc", pc, 2);

    // Reset while the write is waiting for its ack
    reset_on();
    clear_mem();
    set_waits(0, 0, 20, 20, 0);
    dmem[5] = 16'h1234;
    imem[0] = 16'h0005; imem[1] = 16'hE7C8;
    reset_off();
    k = 0;
    while (!(dmem_req && dmem_we) && k < 100) begin
      @(posedge clk); #1; k++;
    end
    check("t6_reach_mem_wr", dmem_req && dmem_we, 1);
    repeat (2) @(posedge clk);
    r0 = n_ret;
    reset_on();
    check("t6_no_write", dmem[5], 16'h1234);
    check("t6_no_retire", n_ret, r0);
    reset_off();

    // Random programs with random wait states, stray valids and mid-run resets
    for (int round = 0; round < 4; round++) begin
      reset_on();
      for (int i = 0; i < 32768; i++) begin
        if ($urandom_range(0, 1) == 1) imem[i] = {1'b0, 15'($urandom)};
        else                           imem[i] = {3'b111, 13'($urandom)};
        dmem[i] = 16'($urandom);
      end
      set_waits(0, $urandom_range(0, 3), 0, $urandom_range(0, 3), 1);
      reset_off();
      run_retires(150, 6000, "rand");
      repeat ($urandom_range(0, 20)) @(posedge clk);
    end

    reset_on();
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish by cycle %0d expected finish earlier", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
